// File: rtl/reg_piso_serializer.sv
// reg_piso_serializer
// Parallel-in / serial-out stage fed by the 8-bit parallel register.
// A word is accepted over a valid/ready handshake while idle and shifted out
// MSB first, one bit per clock, with ser_valid marking each bit. busy covers
// the serial frame and done pulses for one cycle after it.
//
// Optional build macro: REG_PISO_PARITY_EN
//   defined   - an even-parity bit (XOR of the captured word) is appended as
//               one extra serial bit after the data bits.
//   undefined - the frame is exactly WIDTH bits and no parity flop exists.

module reg_piso_serializer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             busy,
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SHIFT  = 2'd1;
`ifdef REG_PISO_PARITY_EN
    localparam logic [1:0] PARITY = 2'd2;
`endif
    localparam logic [1:0] DONE   = 2'd3;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    cnt;
    logic             take;
`ifdef REG_PISO_PARITY_EN
    logic             parity_q;
`endif

    assign take = in_valid & in_ready;

    // Next-state selection for the frame sequencer
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (take) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt == LAST) begin
`ifdef REG_PISO_PARITY_EN
                    state_nxt = PARITY;
`else
                    state_nxt = DONE;
`endif
                end
            end
`ifdef REG_PISO_PARITY_EN
            PARITY: begin
                state_nxt = DONE;
            end
`endif
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Capture on handshake, then shift left with zero fill while serializing;
    // the counter saturates at the last bit index so it never wraps
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg <= '0;
            cnt   <= '0;
        end else if (take) begin
            shreg <= d_in;
            cnt   <= '0;
        end else if (state == SHIFT) begin
            shreg <= {shreg[WIDTH-2:0], 1'b0};
            if (cnt != LAST) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

`ifdef REG_PISO_PARITY_EN
    // Even parity of the captured word, held for the trailing parity bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_q <= 1'b0;
        end else if (take) begin
            parity_q <= ^d_in;
        end
    end
`endif

    // Status and serial outputs decoded from state; in_ready is also gated by
    // rst_n so it reads 0 throughout reset even though the state is IDLE
    always_comb begin
        in_ready  = 1'b0;
        ser_out   = 1'b0;
        ser_valid = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = rst_n;
            end
            SHIFT: begin
                busy      = 1'b1;
                ser_valid = 1'b1;
                ser_out   = shreg[WIDTH-1];
            end
`ifdef REG_PISO_PARITY_EN
            PARITY: begin
                busy      = 1'b1;
                ser_valid = 1'b1;
                ser_out   = parity_q;
            end
`endif
            DONE: begin
                done = 1'b1;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_reg_piso_serializer.sv
// Self-checking bench for reg_piso_serializer (WIDTH = 8).
// Expected serial bits are queued when a word is handed over and popped as
// the DUT emits them. Build with REG_PISO_PARITY_EN to cover the parity bit.

module tb_reg_piso_serializer;

    localparam int WIDTH = 8;
`ifdef REG_PISO_PARITY_EN
    localparam int NB = WIDTH + 1;
`else
    localparam int NB = WIDTH;
`endif

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] d_in;
    logic             in_valid;
    logic             in_ready;
    logic             ser_out;
    logic             ser_valid;
    logic             busy;
    logic             done;

    int n_checks;
    int n_fail;
    logic expq[$];

    reg_piso_serializer #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .d_in     (d_in),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .ser_out  (ser_out),
        .ser_valid(ser_valid),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [WIDTH-1:0] w);
        for (int i = WIDTH - 1; i >= 0; i--) begin
            expq.push_back(w[i]);
        end
`ifdef REG_PISO_PARITY_EN
        expq.push_back(^w);
`endif
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < 64) begin
            tick();
            n++;
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            $display("FAIL %s wait_ready: in_ready=%b required 1 (timeout)", tag, in_ready);
            n_fail++;
        end
    endtask

    // Called in the first cycle after the transfer edge
    task automatic collect_frame(input string tag);
        logic e;
        for (int i = 0; i < NB; i++) begin
            n_checks++;
            if (ser_valid !== 1'b1) begin
                $display("FAIL %s bit%0d ser_valid: got %b required 1", tag, i, ser_valid);
                n_fail++;
            end
            n_checks++;
            if (busy !== 1'b1) begin
                $display("FAIL %s bit%0d busy: got %b required 1", tag, i, busy);
                n_fail++;
            end
            n_checks++;
            if (in_ready !== 1'b0 || done !== 1'b0) begin
                $display("FAIL %s bit%0d ready/done: got %b/%b required 0/0", tag, i, in_ready, done);
                n_fail++;
            end
            n_checks++;
            if (expq.size() == 0) begin
                $display("FAIL %s bit%0d scoreboard: got ser_out=%b required nothing queued", tag, i, ser_out);
                n_fail++;
            end else begin
                e = expq.pop_front();
                if (ser_out !== e) begin
                    $display("FAIL %s bit%0d ser_out: got %b required %b", tag, i, ser_out, e);
                    n_fail++;
                end
            end
            tick();
        end
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0 || ser_valid !== 1'b0 || in_ready !== 1'b0) begin
            $display("FAIL %s done_cycle: done/busy/ser_valid/in_ready got %b%b%b%b required 1000",
                     tag, done, busy, ser_valid, in_ready);
            n_fail++;
        end
        tick();
        n_checks++;
        if (in_ready !== 1'b1 || done !== 1'b0 || ser_valid !== 1'b0) begin
            $display("FAIL %s ready_again: in_ready/done/ser_valid got %b%b%b required 100",
                     tag, in_ready, done, ser_valid);
            n_fail++;
        end
        n_checks++;
        if (expq.size() != 0) begin
            $display("FAIL %s leftover: got %0d queued bits required 0", tag, expq.size());
            n_fail++;
            expq.delete();
        end
    endtask

    task automatic send_word(input logic [WIDTH-1:0] w, input string tag);
        wait_ready(tag);
        d_in     = w;
        in_valid = 1'b1;
        push_word(w);
        tick();
        in_valid = 1'b0;
        d_in     = ~w;
        collect_frame(tag);
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        in_valid = 1'b1;
        d_in     = 8'hFF;
        tick();
        tick();
        n_checks++;
        if ({ser_out, ser_valid, busy, done, in_ready} !== 5'b0) begin
            $display("FAIL reset outputs: got %b required 00000",
                     {ser_out, ser_valid, busy, done, in_ready});
            n_fail++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        tick();
        n_checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            $display("FAIL reset release: in_ready/busy got %b%b required 10", in_ready, busy);
            n_fail++;
        end
        tick();
        n_checks++;
        if (ser_valid !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL reset no_capture: ser_valid/busy got %b%b required 00", ser_valid, busy);
            n_fail++;
        end
    endtask

    task automatic test_all_ones();
        send_word(8'hFF, "all_ones");
    endtask

    task automatic test_pattern();
        send_word(8'b10011001, "pattern99");
    endtask

    task automatic test_holdoff();
        wait_ready("holdoff");
        d_in     = 8'h3C;
        in_valid = 1'b1;
        push_word(8'h3C);
        tick();
        d_in = 8'hA5;
        collect_frame("holdoff_3c");
        push_word(8'hA5);
        tick();
        in_valid = 1'b0;
        collect_frame("holdoff_a5");
    endtask

    task automatic test_reset_midframe();
        logic e;
        wait_ready("midrst");
        d_in     = 8'hF0;
        in_valid = 1'b1;
        push_word(8'hF0);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            e = expq.pop_front();
            n_checks++;
            if (ser_valid !== 1'b1 || ser_out !== e) begin
                $display("FAIL midrst bit%0d: ser_valid/ser_out got %b%b required 1%b", i, ser_valid, ser_out, e);
                n_fail++;
            end
            if (i < 2) tick();
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({ser_out, ser_valid, busy, done, in_ready} !== 5'b0) begin
            $display("FAIL midrst async: outputs got %b required 00000",
                     {ser_out, ser_valid, busy, done, in_ready});
            n_fail++;
        end
        expq.delete();
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        send_word(8'h01, "after_rst");
    endtask

    task automatic test_msb_only();
        send_word(8'b10000000, "msb_only");
    endtask

    task automatic test_random();
        for (int i = 0; i < 4; i++) begin
            send_word(WIDTH'($urandom_range(0, 255)), "random");
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        d_in     = '0;
        test_reset();
        test_all_ones();
        test_pattern();
        test_holdoff();
        test_reset_midframe();
        test_msb_only();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_piso_serializer.md
Name: reg_piso_serializer

Overview:
Downstream stage of the 8-bit parallel register. It takes the register's parallel word over a valid/ready handshake and shifts it out serially, MSB first, one bit per clock. A small FSM drives busy and done status. It is the parallel-in/serial-out consumer of the register's q outputs in the lab datapath.

Parameters:
WIDTH, 8, number of data bits per word; legal range is WIDTH >= 2.

Ports:
clk  input  1  system clock, rising-edge active
rst_n  input  1  asynchronous active-low reset
d_in  input  WIDTH  parallel word from the register; d_in[WIDTH-1] maps to q0
in_valid  input  1  d_in is valid this cycle
in_ready  output  1  block can accept a word this cycle
ser_out  output  1  serial data bit
ser_valid  output  1  ser_out carries a valid bit this cycle
busy  output  1  a word is being serialized
done  output  1  one-cycle pulse after the last bit

Behaviour:
- Interface timing:
  - One clock, clk.
  - Reset is asynchronous and active-low on rst_n.
  - All state updates on the rising edge of clk.
- Reset, while rst_n = 0:
  - state = IDLE.
  - shift register, bit counter and parity register are all 0.
  - ser_out = 0, ser_valid = 0, busy = 0, done = 0, in_ready = 0.
- State IDLE:
  - in_ready = 1; busy, ser_valid and done are 0; ser_out = 0.
  - A transfer happens on a rising edge where in_valid and in_ready are both 1.
  - On a transfer: capture d_in into the shift register, set the counter to 0, latch parity = XOR of d_in, go to SHIFT.
- State SHIFT:
  - in_ready = 0, busy = 1, ser_valid = 1.
  - ser_out = shift register MSB.
  - Each edge: shift left by 1 with zero fill, and counter increments.
  - When counter = WIDTH-1 at an edge: go to PARITY if PARITY_EN is defined, otherwise go to DONE.
- State DONE:
  - done = 1, busy = 0, ser_valid = 0, in_ready = 0.
  - Next edge goes to IDLE unconditionally.
- Latency, for a transfer at edge k:
  - bits appear in cycles k+1 .. k+WIDTH;
  - done is high in cycle k+WIDTH+1;
  - in_ready is high again in cycle k+WIDTH+2.
  - Each of these shifts one cycle later with PARITY_EN.
- Counter width is $clog2(WIDTH). The counter never wraps past WIDTH-1.
- in_valid while not in IDLE: ignored, no capture. The upstream register must hold its word until in_ready is seen high.
- d_in changes after capture have no effect on the current word.
- Reset mid-operation:
  - Outputs go to their reset values immediately, without waiting for a clock.
  - The partial word is discarded.
  - The block restarts in IDLE after rst_n returns to 1.
- No back-to-back transfers. The minimum period between transfers is WIDTH+2 cycles, or WIDTH+3 with PARITY_EN.

Optional Feature:
Macro REG_PISO_PARITY_EN.
- Defined:
  - An extra state PARITY follows the last data bit.
  - In PARITY, ser_out = latched even-parity bit (XOR of the captured word), ser_valid = 1, busy = 1.
  - Next edge goes to DONE.
- Not defined:
  - No PARITY state; the frame is exactly WIDTH serial bits.
  - The parity register is not built.

Test Plan:
1. Reset: hold rst_n = 0 with in_valid = 1 -> ser_out, ser_valid, busy, done and in_ready all 0, with no capture. After release -> in_ready = 1.
2. d_in = 8'b11111111, in_valid pulsed -> ser_out = 1 with ser_valid = 1 for 8 cycles, done = 1 in cycle 9, in_ready = 1 in cycle 10.
3. d_in = 8'b10011001 -> ser_out sequence 1,0,0,1,1,0,0,1. With REG_PISO_PARITY_EN, a ninth bit 0 follows.
4. Hold off: accept 8'h3C, then hold in_valid = 1 with d_in = 8'hA5 during the shift -> only 0,0,1,1,1,1,0,0 is emitted. 8'hA5 is captured at the first IDLE edge and gives 1,0,1,0,0,1,0,1.
5. Assert rst_n = 0 asynchronously after 3 bits of 8'hF0 -> ser_valid and busy drop before the next edge. After release, 8'h01 gives 0,0,0,0,0,0,0,1 with done on time.
6. With REG_PISO_PARITY_EN: d_in = 8'b10000000 -> data bits 1,0,0,0,0,0,0,0, then parity bit 1, then done in cycle 10.
